// File: rtl/edge_detect_array_if.sv
// edge_detect_array_if: channel bus between the edge detector and its user
// master: drives data_in, rise_en, fall_en, clr; receives level_out, pulse_out, evt_flag, irq
// slave:  the detector side of the same signals
interface edge_detect_array_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] pulse_out;
  logic [WIDTH-1:0] evt_flag;
  logic             irq;
  modport master (
    output data_in, rise_en, fall_en, clr,
    input  level_out, pulse_out, evt_flag, irq
  );
  modport slave (
    input  data_in, rise_en, fall_en, clr,
    output level_out, pulse_out, evt_flag, irq
  );
endinterface

// File: rtl/edge_detect_array.sv
// edge_detect_array: per-channel synchroniser, glitch filter, edge pulse, sticky flag and shared irq
// clk, rst (async, active-high) plain ports; bus.slave carries data_in/rise_en/fall_en/clr in
// and level_out/pulse_out/evt_flag/irq out
module edge_detect_array #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 1
) (
  input logic                clk,
  input logic                rst,
  edge_detect_array_if.slave bus
);
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [WIDTH-1:0]         s;
  logic [WIDTH-1:0]         filt_q, filt_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         pulse_q, pulse_d;
  logic [WIDTH-1:0]         evt_q, evt_d;
  logic [WIDTH-1:0]         acc;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = bus.data_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    always_comb begin
      sync_d[0] = bus.data_in;
      for (int j = 1; j < SYNC_STAGES; j++) sync_d[j] = sync_q[j-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
    end
    assign s = sync_q[SYNC_STAGES-1];
  end
  // A channel accepts once its synchronised value has differed from the
  // accepted level for FILTER_LEN consecutive cycles; any match restarts the count.
  always_comb begin
    acc     = '0;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc[i]     = (s[i] != filt_q[i]) && (cnt_q[i] == CW'(FILTER_LEN - 1));
      filt_d[i]  = acc[i] ? s[i] : filt_q[i];
      cnt_d[i]   = (s[i] == filt_q[i] || acc[i]) ? '0 : cnt_q[i] + CW'(1);
      pulse_d[i] = acc[i] & (s[i] ? bus.rise_en[i] : bus.fall_en[i]);
    end
    // set has priority over a simultaneous clear
    evt_d = pulse_d | (evt_q & ~bus.clr);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q  <= '0;
      cnt_q   <= '0;
      pulse_q <= '0;
      evt_q   <= '0;
    end else begin
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      evt_q   <= evt_d;
    end
  end
  assign bus.level_out = filt_q;
  assign bus.pulse_out = pulse_q;
  assign bus.evt_flag  = evt_q;
  assign bus.irq       = |evt_q;
endmodule
